// File: rtl/accumulator_pkg.sv
// Shared types and constants for the sample accumulator and its adder.
package accumulator_pkg;

  // Datapath word width for samples and the running sum.
  localparam int WORD_WIDTH = 16;

  // Window control states: waiting for the first sample, collecting samples,
  // and holding a completed result until cleared.
  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_t;

endpackage : accumulator_pkg

// File: rtl/adder_16bit.sv
// 16-bit unsigned adder with carry-in; overflow is the carry out of bit 15.
module adder_16bit
  import accumulator_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  input  logic                  carry_in,
  output logic [WORD_WIDTH-1:0] sum,
  output logic                  overflow
);

  logic [WORD_WIDTH:0] wide_sum;

  // Widen by one bit so the carry out of the top bit lands in the MSB.
  always_comb begin
    wide_sum = {1'b0, a} + {1'b0, b} + {{WORD_WIDTH{1'b0}}, carry_in};
  end

  assign sum      = wide_sum[WORD_WIDTH-1:0];
  assign overflow = wide_sum[WORD_WIDTH];

endmodule : adder_16bit

// File: rtl/sample_accumulator.sv
// Sums a fixed-size window of unsigned samples taken over a valid/ready
// handshake, tracks whether any add wrapped, and holds the result until
// the window is cleared.
module sample_accumulator
  import accumulator_pkg::*;
#(
  parameter int NUM_SAMPLES = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [WORD_WIDTH-1:0]  data_in,
  input  logic                   data_valid,
  input  logic                   clear,
  output logic                   ready,
  output logic [WORD_WIDTH-1:0]  accum,
  output logic [COUNT_WIDTH-1:0] sample_count,
  output logic                   overflow_flag,
  output logic                   done
);

  // Count value reached by the final sample of a window.
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(NUM_SAMPLES);

  acc_state_t             state;
  acc_state_t             next_state;
  logic                   accept;
  logic [WORD_WIDTH-1:0]  sum;
  logic                   carry;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic                   last_sample;

  // Datapath: the adder always proposes accum + data_in; the registers
  // only take it on an accepted sample.
  adder_16bit u_adder (
    .a        (accum),
    .b        (data_in),
    .carry_in (1'b0),
    .sum      (sum),
    .overflow (carry)
  );

  // A sample is taken only when offered, when there is room for it, and
  // when no clear is pending; clear always wins.
  assign accept      = data_valid && ready && !clear;
  assign count_inc   = sample_count + 1'b1;
  assign last_sample = (count_inc == LAST_COUNT);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; the sample that fills the window moves us to HOLD,
  // which also covers a one-sample window straight out of IDLE.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state
    // unassigned, which would otherwise infer a latch.
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            next_state = last_sample ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          next_state = HOLD;
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decoded from the state register alone.
  always_comb begin
    done  = 1'b0;
    ready = 1'b1;
    if (state == HOLD) begin
      done  = 1'b1;
      ready = 1'b0;
    end
  end

  // Accumulate, count and sticky-overflow registers. In IDLE accum is
  // zero so the adder cannot carry, and the flag stays clear on the first
  // sample; in HOLD ready is low so nothing is accepted and all freeze.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      accum         <= '0;
      sample_count  <= '0;
      overflow_flag <= 1'b0;
    end else if (clear) begin
      accum         <= '0;
      sample_count  <= '0;
      overflow_flag <= 1'b0;
    end else if (accept) begin
      accum         <= sum;
      sample_count  <= count_inc;
      overflow_flag <= overflow_flag | carry;
    end
  end

endmodule : sample_accumulator

// File: tb/tb_sample_accumulator.sv
// Self-checking bench for sample_accumulator: directed scenarios plus
// random traffic, each cycle's expected outputs queued by the driver and
// compared by an independent monitor.
module tb_sample_accumulator;

  localparam int NUM = 8;
  localparam int CW  = 4;

  logic          clk;
  logic          n_rst;
  logic [15:0]   data_in;
  logic          data_valid;
  logic          clear;
  logic          ready;
  logic [15:0]   accum;
  logic [CW-1:0] sample_count;
  logic          overflow_flag;
  logic          done;

  int total;
  int bad;

  typedef struct {
    logic [15:0] accum;
    int          count;
    logic        flag;
    logic        done;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: the true (unwrapped) sum of the window and how many
  // samples it holds. Wrap happened iff the true sum left 16 bits.
  longint m_total;
  int     m_count;

  sample_accumulator #(
    .NUM_SAMPLES (NUM),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .clear         (clear),
    .ready         (ready),
    .accum         (accum),
    .sample_count  (sample_count),
    .overflow_flag (overflow_flag),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    longint wrapped;
    wrapped = m_total % 65536;
    e.accum = 16'(wrapped);
    e.count = m_count;
    e.flag  = (m_total > 65535);
    e.done  = (m_count == NUM);
    return e;
  endfunction

  // One clock cycle of stimulus; the model decides what the DUT must show
  // after the coming rising edge.
  task automatic drive(input logic v, input logic [15:0] d, input logic c);
    @(negedge clk);
    data_valid = v;
    data_in    = d;
    clear      = c;
    if (c) begin
      m_total = 0;
      m_count = 0;
    end else if (v && m_count < NUM) begin
      m_total = m_total + longint'(d);
      m_count = m_count + 1;
    end
    exp_q.push_back(snapshot());
  endtask

  // Asynchronous reset between edges; outputs must clear at once.
  task automatic reset_mid_cycle();
    @(negedge clk);
    data_valid = 1'b0;
    clear      = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    check("rst_accum", accum, 0);
    check("rst_count", sample_count, 0);
    check("rst_flag", overflow_flag, 0);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    m_total = 0;
    m_count = 0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Monitor: after every rising edge, compare the DUT with the oldest
  // queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("accum", accum, e.accum);
        check("sample_count", sample_count, e.count);
        check("overflow_flag", overflow_flag, e.flag);
        check("done", done, e.done);
        check("ready", ready, !e.done);
      end
    end
  end

  initial begin
    total      = 0;
    bad        = 0;
    m_total    = 0;
    m_count    = 0;
    n_rst      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    clear      = 1'b0;

    #3;
    check("por_accum", accum, 0);
    check("por_count", sample_count, 0);
    check("por_ready", ready, 1);
    check("por_done", done, 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Basic window of eight ones, then HOLD must ignore further samples.
    for (int i = 0; i < NUM; i++) drive(1'b1, 16'h0001, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h1234, 1'b0);

    // Clear with a sample in HOLD drops it; the next cycle's sample counts.
    drive(1'b1, 16'h5555, 1'b1);
    drive(1'b1, 16'h0001, 1'b0);

    // Wrap-around: FFFA + 1 = FFFB, + 7 wraps to 0002 with flag sticky.
    drive(1'b0, 16'h0000, 1'b1);
    drive(1'b1, 16'hFFFA, 1'b0);
    drive(1'b1, 16'h0001, 1'b0);
    drive(1'b1, 16'h0007, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 16'h0100, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);

    // Clear priority in ACCUM with accum = 5.
    drive(1'b0, 16'h0000, 1'b1);
    drive(1'b1, 16'h0002, 1'b0);
    drive(1'b1, 16'h0003, 1'b0);
    drive(1'b1, 16'h0003, 1'b1);
    drive(1'b0, 16'h0000, 1'b0);

    // Idle gaps between two samples: AAFF + FFAA wraps to AAA9.
    drive(1'b1, 16'hAAFF, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 16'hDEAD, 1'b0);
    drive(1'b1, 16'hFFAA, 1'b0);

    // Reset in the middle of that window.
    reset_mid_cycle();

    // Random traffic: mixed valid density, occasional clears, and data that
    // is sometimes small (long windows without wrap) and sometimes large.
    for (int i = 0; i < 400; i++) begin
      logic        v;
      logic        c;
      logic [15:0] d;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 1) d = 16'($urandom);
      else d = 16'($urandom_range(0, 255));
      drive(v, d, c);
    end

    drive(1'b0, 16'h0000, 1'b0);
    drive(1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sample_accumulator
